// File: rtl/rename_unit.sv
// Multi-way register rename stage: mapping table, free list and circular branch
// checkpoints with single-cycle recovery. Results are registered (1-cycle latency).
// CP_NUM is assumed to be a power of two so checkpoint pointers wrap naturally.
module rename_unit #(
  parameter int unsigned WAYS     = 4,
  parameter int unsigned ARF_SIZE = 32,
  parameter int unsigned PRF_SIZE = 64,
  parameter int unsigned CP_NUM   = 4,
  localparam int unsigned AW = $clog2(ARF_SIZE),
  localparam int unsigned PW = $clog2(PRF_SIZE),
  localparam int unsigned CW = $clog2(CP_NUM)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WAYS-1:0]    inst_valid,
  input  logic [WAYS*AW-1:0] src_l,
  input  logic [WAYS*AW-1:0] src_r,
  input  logic [WAYS*AW-1:0] dst,
  input  logic [WAYS-1:0]    dst_valid,
  input  logic               ckpt_req,
  output logic               out_valid,
  output logic [WAYS*PW-1:0] prs_l,
  output logic [WAYS*PW-1:0] prs_r,
  output logic [WAYS*PW-1:0] prd,
  output logic [WAYS*PW-1:0] old_prd,
  output logic [CW-1:0]      out_ckpt_tag,
  input  logic [WAYS-1:0]    commit_valid,
  input  logic [WAYS*PW-1:0] commit_prd,
  input  logic               ckpt_release,
  input  logic               recover,
  input  logic [CW-1:0]      recover_tag,
  output logic [PW:0]        free_count
);

  // p0..p(ARF_SIZE-1) hold the identity mapping out of reset.
  localparam logic [PRF_SIZE-1:0] FreeInit = {PRF_SIZE{1'b1}} << ARF_SIZE;

  logic [PW-1:0]       map_q      [ARF_SIZE];
  logic [PW-1:0]       map_d      [ARF_SIZE];
  logic [PRF_SIZE-1:0] free_q, free_d;
  logic [PW-1:0]       cp_map_q   [CP_NUM][ARF_SIZE];
  logic [PW-1:0]       cp_map_d   [CP_NUM][ARF_SIZE];
  logic [PRF_SIZE-1:0] cp_alloc_q [CP_NUM];
  logic [PRF_SIZE-1:0] cp_alloc_d [CP_NUM];
  logic [CW-1:0]       head_q, head_d, tail_q, tail_d;
  logic [CW:0]         ckpt_count_q, ckpt_count_d;

  logic                out_valid_q, out_valid_d;
  logic [WAYS*PW-1:0]  prs_l_q, prs_l_d, prs_r_q, prs_r_d;
  logic [WAYS*PW-1:0]  prd_q, prd_d, old_prd_q, old_prd_d;
  logic [CW-1:0]       out_ckpt_tag_q, out_ckpt_tag_d;

  logic [WAYS-1:0]     need;
  logic [PW:0]         need_cnt, free_cnt;
  logic                fire;
  logic [PW-1:0]       alloc_tag [WAYS];
  logic [PRF_SIZE-1:0] alloc_mask, avail;
  logic                found;
  logic [AW-1:0]       sl, sr, sd;
  logic [PW-1:0]       rl, rr, ro;
  logic [WAYS*PW-1:0]  prs_l_new, prs_r_new, old_prd_new, prd_new;
  logic                rel;
  logic [CW-1:0]       head_rel, rec_off, slot_off;
  logic [CW:0]         count_rel;
  logic                rec_ok;

  // Free-register count and handshake.
  always_comb begin
    free_cnt = '0;
    for (int t = 0; t < PRF_SIZE; t++) free_cnt = free_cnt + (PW+1)'(free_q[t]);
    need     = '0;
    need_cnt = '0;
    for (int i = 0; i < WAYS; i++) begin
      need[i]  = inst_valid[i] && dst_valid[i] && (dst[i*AW +: AW] != '0);
      need_cnt = need_cnt + (PW+1)'(need[i]);
    end
    in_ready = !recover && (free_cnt >= need_cnt) &&
               (!ckpt_req || (ckpt_count_q < (CW+1)'(CP_NUM)));
    fire     = in_valid && in_ready;
  end

  // Hand out the lowest free tags to needing ways, lowest way first.
  always_comb begin
    avail      = free_q;
    alloc_mask = '0;
    found      = 1'b0;
    for (int i = 0; i < WAYS; i++) begin
      alloc_tag[i] = '0;
      found        = 1'b0;
      if (need[i]) begin
        for (int t = 0; t < PRF_SIZE; t++) begin
          if (!found && avail[t]) begin
            alloc_tag[i]  = PW'(t);
            avail[t]      = 1'b0;
            alloc_mask[t] = 1'b1;
            found         = 1'b1;
          end
        end
      end
    end
  end

  // Source/old-destination lookup with bypass from older ways in the same group.
  always_comb begin
    prs_l_new   = '0;
    prs_r_new   = '0;
    old_prd_new = '0;
    prd_new     = '0;
    sl = '0; sr = '0; sd = '0;
    rl = '0; rr = '0; ro = '0;
    for (int i = 0; i < WAYS; i++) begin
      sl = src_l[i*AW +: AW];
      sr = src_r[i*AW +: AW];
      sd = dst[i*AW +: AW];
      rl = map_q[sl];
      rr = map_q[sr];
      ro = map_q[sd];
      // Later matching ways overwrite earlier ones, so the youngest older writer wins.
      for (int j = 0; j < WAYS; j++) begin
        if (j < i && need[j]) begin
          if (dst[j*AW +: AW] == sl) rl = alloc_tag[j];
          if (dst[j*AW +: AW] == sr) rr = alloc_tag[j];
          if (dst[j*AW +: AW] == sd) ro = alloc_tag[j];
        end
      end
      prs_l_new[i*PW +: PW]   = rl;
      prs_r_new[i*PW +: PW]   = rr;
      old_prd_new[i*PW +: PW] = need[i] ? ro : '0;
      prd_new[i*PW +: PW]     = alloc_tag[i];
    end
  end

  // Next state for map, free list and checkpoint ring.
  always_comb begin
    map_d        = map_q;
    free_d       = free_q;
    cp_map_d     = cp_map_q;
    cp_alloc_d   = cp_alloc_q;
    tail_d       = tail_q;
    slot_off     = '0;
    // Release is applied before any recovery in the same cycle.
    rel          = ckpt_release && (ckpt_count_q != '0);
    head_rel     = head_q + CW'(rel);
    count_rel    = ckpt_count_q - (CW+1)'(rel);
    rec_off      = recover_tag - head_rel;
    rec_ok       = {1'b0, rec_off} < count_rel;
    head_d       = head_rel;
    ckpt_count_d = count_rel;
    if (recover) begin
      map_d  = cp_map_q[recover_tag];
      free_d = free_q | cp_alloc_q[recover_tag];
      // Tags returned here must not be returned again by an older checkpoint.
      for (int k = 0; k < CP_NUM; k++) cp_alloc_d[k] = cp_alloc_q[k] & ~cp_alloc_q[recover_tag];
      tail_d       = recover_tag + CW'(1);
      ckpt_count_d = {1'b0, rec_off} + (CW+1)'(1);
    end else if (fire) begin
      for (int i = 0; i < WAYS; i++) begin
        if (need[i]) map_d[dst[i*AW +: AW]] = alloc_tag[i];
      end
      free_d = free_q & ~alloc_mask;
      for (int k = 0; k < CP_NUM; k++) begin
        slot_off = CW'(k) - head_q;
        if ({1'b0, slot_off} < ckpt_count_q) cp_alloc_d[k] = cp_alloc_q[k] | alloc_mask;
      end
      if (ckpt_req) begin
        cp_map_d[tail_q]   = map_d;
        cp_alloc_d[tail_q] = '0;
        tail_d             = tail_q + CW'(1);
        ckpt_count_d       = count_rel + (CW+1)'(1);
      end
    end
    for (int k = 0; k < WAYS; k++) begin
      if (commit_valid[k] && (commit_prd[k*PW +: PW] != '0)) free_d[commit_prd[k*PW +: PW]] = 1'b1;
    end
  end

  // Registered rename results; payload holds between fires.
  always_comb begin
    out_valid_d    = fire;
    prs_l_d        = fire ? prs_l_new : prs_l_q;
    prs_r_d        = fire ? prs_r_new : prs_r_q;
    prd_d          = fire ? prd_new : prd_q;
    old_prd_d      = fire ? old_prd_new : old_prd_q;
    out_ckpt_tag_d = fire ? (ckpt_req ? tail_q : '0) : out_ckpt_tag_q;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < ARF_SIZE; i++) map_q[i] <= PW'(i);
      free_q <= FreeInit;
      for (int k = 0; k < CP_NUM; k++) begin
        cp_alloc_q[k] <= '0;
        for (int i = 0; i < ARF_SIZE; i++) cp_map_q[k][i] <= '0;
      end
      head_q         <= '0;
      tail_q         <= '0;
      ckpt_count_q   <= '0;
      out_valid_q    <= 1'b0;
      prs_l_q        <= '0;
      prs_r_q        <= '0;
      prd_q          <= '0;
      old_prd_q      <= '0;
      out_ckpt_tag_q <= '0;
    end else begin
      map_q          <= map_d;
      free_q         <= free_d;
      cp_map_q       <= cp_map_d;
      cp_alloc_q     <= cp_alloc_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      ckpt_count_q   <= ckpt_count_d;
      out_valid_q    <= out_valid_d;
      prs_l_q        <= prs_l_d;
      prs_r_q        <= prs_r_d;
      prd_q          <= prd_d;
      old_prd_q      <= old_prd_d;
      out_ckpt_tag_q <= out_ckpt_tag_d;
    end
  end

  // Illegal-usage checks: recovery to a dead checkpoint, double free.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (recover) begin
        assert (rec_ok) else $error("rename_unit: recover to invalid checkpoint %0d", recover_tag);
      end
      for (int k = 0; k < WAYS; k++) begin
        if (commit_valid[k] && (commit_prd[k*PW +: PW] != '0)) begin
          assert (!free_q[commit_prd[k*PW +: PW]])
            else $error("rename_unit: tag %0d freed while already free", commit_prd[k*PW +: PW]);
        end
      end
    end
  end

  assign out_valid    = out_valid_q;
  assign prs_l        = prs_l_q;
  assign prs_r        = prs_r_q;
  assign prd          = prd_q;
  assign old_prd      = old_prd_q;
  assign out_ckpt_tag = out_ckpt_tag_q;
  assign free_count   = free_cnt;

endmodule

// File: tb/tb_rename_unit.sv
// Directed bench for rename_unit: allocation, bypass, drain/commit, checkpoints.
module tb_rename_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  inst_valid;
  logic [19:0] src_l, src_r, dst;
  logic [3:0]  dst_valid;
  logic        ckpt_req;
  logic        out_valid;
  logic [23:0] prs_l, prs_r, prd, old_prd;
  logic [1:0]  out_ckpt_tag;
  logic [3:0]  commit_valid;
  logic [23:0] commit_prd;
  logic        ckpt_release;
  logic        recover;
  logic [1:0]  recover_tag;
  logic [6:0]  free_count;

  int n_checks = 0;
  int n_errors = 0;

  rename_unit dut (
    .clock        (clock),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .inst_valid   (inst_valid),
    .src_l        (src_l),
    .src_r        (src_r),
    .dst          (dst),
    .dst_valid    (dst_valid),
    .ckpt_req     (ckpt_req),
    .out_valid    (out_valid),
    .prs_l        (prs_l),
    .prs_r        (prs_r),
    .prd          (prd),
    .old_prd      (old_prd),
    .out_ckpt_tag (out_ckpt_tag),
    .commit_valid (commit_valid),
    .commit_prd   (commit_prd),
    .ckpt_release (ckpt_release),
    .recover      (recover),
    .recover_tag  (recover_tag),
    .free_count   (free_count)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [19:0] p5(input int a, input int b, input int c, input int d);
    return {5'(d), 5'(c), 5'(b), 5'(a)};
  endfunction

  function automatic logic [23:0] p6(input int a, input int b, input int c, input int d);
    return {6'(d), 6'(c), 6'(b), 6'(a)};
  endfunction

  task automatic fire_group(input logic [19:0] d, input logic [19:0] sl, input logic [19:0] sr,
                            input logic [3:0] dv, input logic ck);
    in_valid = 1'b1; inst_valid = 4'hf; dst = d; src_l = sl; src_r = sr;
    dst_valid = dv; ckpt_req = ck;
    #1;
    check_eq("group_in_ready", in_ready, 1);
    @(posedge clock); #1;
    in_valid = 1'b0; inst_valid = '0; dst_valid = '0; ckpt_req = 1'b0;
  endtask

  task automatic commit4(input logic [23:0] tags);
    commit_valid = 4'hf; commit_prd = tags;
    @(posedge clock); #1;
    commit_valid = '0; commit_prd = '0;
  endtask

  task automatic do_recover(input logic [1:0] t, input logic rel);
    recover = 1'b1; recover_tag = t; ckpt_release = rel;
    #1;
    check_eq("recover_in_ready", in_ready, 0);
    @(posedge clock); #1;
    recover = 1'b0; ckpt_release = 1'b0;
  endtask

  initial begin
    reset = 1'b1; in_valid = 0; inst_valid = 0; src_l = 0; src_r = 0; dst = 0; dst_valid = 0;
    ckpt_req = 0; commit_valid = 0; commit_prd = 0; ckpt_release = 0; recover = 0;
    recover_tag = 0;
    repeat (2) @(posedge clock);
    #1; reset = 1'b0;
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_free_count", free_count, 32);
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_prd", prd, 0);
    check_eq("rst_ckpt_tag", out_ckpt_tag, 0);

    // Basic group
    fire_group(p5(1, 2, 3, 4), '0, '0, 4'hf, 1'b0);
    check_eq("a_out_valid", out_valid, 1);
    check_eq("a_prd", prd, p6(32, 33, 34, 35));
    check_eq("a_old_prd", old_prd, p6(1, 2, 3, 4));
    check_eq("a_free_count", free_count, 28);
    @(posedge clock); #1;
    check_eq("idle_out_valid", out_valid, 0);

    // Intra-group bypass
    fire_group(p5(5, 6, 5, 7), p5(1, 5, 2, 0), p5(0, 0, 0, 5), 4'hf, 1'b0);
    check_eq("b_prd", prd, p6(36, 37, 38, 39));
    check_eq("b_prs_l", prs_l, p6(32, 36, 33, 0));
    check_eq("b_prs_r", prs_r, p6(0, 0, 0, 38));
    check_eq("b_old_prd", old_prd, p6(5, 6, 36, 7));
    check_eq("b_free_count", free_count, 24);

    // x0 destinations allocate nothing; map reads after group b
    fire_group(p5(0, 0, 0, 0), p5(5, 0, 0, 7), '0, 4'hf, 1'b0);
    check_eq("c_prd", prd, 0);
    check_eq("c_prs_l", prs_l, p6(38, 0, 0, 39));
    check_eq("c_free_count", free_count, 24);

    // Drain the free list
    for (int g = 0; g < 6; g++) fire_group(p5(8, 9, 10, 11), '0, '0, 4'hf, 1'b0);
    check_eq("drain_last_prd", prd, p6(60, 61, 62, 63));
    check_eq("drain_free_count", free_count, 0);
    inst_valid = 4'hf; dst = p5(12, 13, 14, 15); dst_valid = 4'hf; src_l = '0; src_r = '0;
    #1;
    check_eq("drain_ready_low", in_ready, 0);
    dst_valid = 4'h0;
    #1;
    check_eq("drain_no_need_ready", in_ready, 1);
    dst_valid = 4'hf;
    commit_valid = 4'hf; commit_prd = p6(1, 2, 3, 4); in_valid = 1'b1;
    #1;
    check_eq("commit_no_bypass", in_ready, 0);
    @(posedge clock); #1;
    commit_valid = '0; commit_prd = '0;
    check_eq("commit_free_count", free_count, 4);
    check_eq("commit_ready_back", in_ready, 1);
    @(posedge clock); #1;
    in_valid = 1'b0; inst_valid = '0; dst_valid = '0;
    check_eq("reuse_prd", prd, p6(1, 2, 3, 4));
    check_eq("reuse_free_count", free_count, 0);

    commit4(p6(5, 6, 7, 36));
    commit4(p6(8, 9, 10, 11));
    for (int g = 0; g < 5; g++) commit4(p6(40 + 4*g, 41 + 4*g, 42 + 4*g, 43 + 4*g));
    check_eq("refill_free_count", free_count, 28);

    // Checkpoint, three groups, checkpoint, recover to the first
    fire_group(p5(16, 17, 18, 19), '0, '0, 4'hf, 1'b1);
    check_eq("cp0_tag", out_ckpt_tag, 0);
    check_eq("cp0_prd", prd, p6(5, 6, 7, 8));
    fire_group(p5(20, 21, 22, 23), '0, '0, 4'hf, 1'b0);
    check_eq("g1_prd", prd, p6(9, 10, 11, 36));
    fire_group(p5(16, 17, 18, 19), '0, '0, 4'hf, 1'b0);
    check_eq("g2_old_prd", old_prd, p6(5, 6, 7, 8));
    check_eq("g2_prd", prd, p6(40, 41, 42, 43));
    fire_group(p5(24, 25, 26, 27), '0, '0, 4'hf, 1'b0);
    fire_group(p5(0, 0, 0, 0), '0, '0, 4'h0, 1'b1);
    check_eq("cp1_tag", out_ckpt_tag, 1);
    check_eq("pre_rec_free_count", free_count, 12);
    check_eq("pre_rec_ckpt_count", dut.ckpt_count_q, 2);
    do_recover(2'd0, 1'b0);
    check_eq("rec_out_valid", out_valid, 0);
    check_eq("rec_free_count", free_count, 24);
    check_eq("rec_ckpt_count", dut.ckpt_count_q, 1);
    fire_group(p5(28, 0, 0, 0), p5(16, 20, 24, 5), '0, 4'b0001, 1'b0);
    check_eq("rec_map", prs_l, p6(5, 20, 24, 38));
    check_eq("rec_prd", prd, p6(9, 0, 0, 0));

    // Fill all checkpoint slots
    for (int g = 0; g < 3; g++) begin
      fire_group(p5(0, 0, 0, 0), '0, '0, 4'h0, 1'b1);
      check_eq("fill_tag", out_ckpt_tag, g + 1);
    end
    in_valid = 1'b1; inst_valid = 4'hf; dst_valid = 4'h0; ckpt_req = 1'b1;
    #1;
    check_eq("full_ckpt_blocked", in_ready, 0);
    ckpt_req = 1'b0;
    #1;
    check_eq("full_plain_ready", in_ready, 1);
    in_valid = 1'b0; inst_valid = '0;
    ckpt_release = 1'b1;
    @(posedge clock); #1;
    ckpt_release = 1'b0;
    check_eq("release_count", dut.ckpt_count_q, 3);
    fire_group(p5(29, 0, 0, 0), '0, '0, 4'b0001, 1'b1);
    check_eq("wrap_tag", out_ckpt_tag, 0);
    check_eq("wrap_prd", prd, p6(10, 0, 0, 0));
    check_eq("wrap_old_prd", old_prd, p6(29, 0, 0, 0));
    check_eq("wrap_free_count", free_count, 22);

    // Release head (slot 1) and recover to slot 3 together
    do_recover(2'd3, 1'b1);
    check_eq("relrec_ckpt_count", dut.ckpt_count_q, 2);
    check_eq("relrec_free_count", free_count, 23);
    fire_group(p5(30, 0, 0, 0), p5(29, 0, 0, 0), '0, 4'b0001, 1'b0);
    check_eq("relrec_map", prs_l, p6(29, 0, 0, 0));
    check_eq("relrec_prd", prd, p6(10, 0, 0, 0));

    // Reset mid-operation
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    check_eq("rst2_out_valid", out_valid, 0);
    check_eq("rst2_free_count", free_count, 32);
    check_eq("rst2_ckpt_count", dut.ckpt_count_q, 0);
    fire_group(p5(1, 2, 3, 4), p5(29, 16, 5, 0), '0, 4'hf, 1'b0);
    check_eq("rst2_prd", prd, p6(32, 33, 34, 35));
    check_eq("rst2_prs_l", prs_l, p6(29, 16, 5, 0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
